// File: rtl/dec_unbinder_seq.sv
// Sequential unbinder: undoes the per-feature rotation of each bound hypervector in a frame.
// Optional DEC_UNBINDER_POPCOUNT_EN adds a registered popcount of level_hv (out_popcnt).
module dec_unbinder_seq #(
    parameter int HV_DIM       = 1024,
    parameter int NUM_FEATURES = 8,
    parameter int SHIFT_BASE   = 93,
    parameter int SHIFT_STEP   = 1
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            start_decoding,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [HV_DIM-1:0]               bound_hv,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [HV_DIM-1:0]               level_hv,
    output logic [$clog2(NUM_FEATURES)-1:0] out_feat_idx,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done
`ifdef DEC_UNBINDER_POPCOUNT_EN
    ,
    output logic [$clog2(HV_DIM+1)-1:0]     out_popcnt
`endif
);

    localparam int IDX_W = $clog2(NUM_FEATURES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [IDX_W-1:0]  k_reg;
    logic              accept;
    logic              drain_done;
    logic [HV_DIM-1:0] rot [NUM_FEATURES];
    logic [HV_DIM-1:0] rot_sel;

    // One constant right-rotation per feature; 64-bit math keeps base + k*step exact
    // before the modulo, and the second modulo folds negative steps into range.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FEATURES; gi++) begin : g_rot
            localparam longint SHIFT_RAW = longint'(SHIFT_BASE) + longint'(gi) * longint'(SHIFT_STEP);
            localparam int     SHIFT_K   = int'(((SHIFT_RAW % longint'(HV_DIM)) + longint'(HV_DIM))
                                               % longint'(HV_DIM));
            assign rot[gi] = HV_DIM'({bound_hv, bound_hv} >> SHIFT_K);
        end
    endgenerate

    always_comb begin
        rot_sel = rot[k_reg];
    end

    assign accept = in_valid && in_ready;
    assign busy   = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        drain_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_decoding) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready && (k_reg == LAST_IDX)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The last beat leaves the output register this cycle (or already has).
                if (!out_valid || out_ready) begin
                    state_next = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg    <= IDLE;
            k_reg        <= '0;
            out_valid    <= 1'b0;
            level_hv     <= '0;
            out_feat_idx <= '0;
            out_last     <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_reg <= state_next;
            done      <= drain_done;

            if ((state_reg == IDLE) && start_decoding) begin
                k_reg <= '0;
            end else if (accept) begin
                k_reg <= (k_reg == LAST_IDX) ? '0 : k_reg + IDX_W'(1);
            end

            if (accept) begin
                out_valid    <= 1'b1;
                level_hv     <= rot_sel;
                out_feat_idx <= k_reg;
                out_last     <= (k_reg == LAST_IDX);
            end else if (out_ready) begin
                out_valid    <= 1'b0;
            end
        end
    end

`ifdef DEC_UNBINDER_POPCOUNT_EN
    localparam int PC_W = $clog2(HV_DIM + 1);

    function automatic logic [PC_W-1:0] count_ones(input logic [HV_DIM-1:0] v);
        logic [PC_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < HV_DIM; i++) begin
            acc = acc + PC_W'(v[i]);
        end
        return acc;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_popcnt <= '0;
        end else if (accept) begin
            out_popcnt <= count_ones(rot_sel);
        end
    end
`endif

endmodule

// File: tb/tb_dec_unbinder_seq.sv
// Scoreboard bench for dec_unbinder_seq (HV_DIM=16, NUM_FEATURES=4, SHIFT_BASE=3, SHIFT_STEP=5).
`timescale 1ns/1ps
module tb_dec_unbinder_seq;

    localparam int HV = 16;
    localparam int NF = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          start_decoding = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [HV-1:0] bound_hv = '0;
    logic          in_ready;
    logic          out_valid;
    logic [HV-1:0] level_hv;
    logic [IW-1:0] out_feat_idx;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef DEC_UNBINDER_POPCOUNT_EN
    logic [4:0]    out_popcnt;
`endif

    dec_unbinder_seq #(
        .HV_DIM(HV), .NUM_FEATURES(NF), .SHIFT_BASE(3), .SHIFT_STEP(5)
    ) dut (
        .clk(clk), .nrst(nrst), .start_decoding(start_decoding),
        .in_valid(in_valid), .in_ready(in_ready), .bound_hv(bound_hv),
        .out_valid(out_valid), .out_ready(out_ready), .level_hv(level_hv),
        .out_feat_idx(out_feat_idx), .out_last(out_last), .busy(busy), .done(done)
`ifdef DEC_UNBINDER_POPCOUNT_EN
        , .out_popcnt(out_popcnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HV-1:0] lvl;
        int            idx;
        bit            last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   pop_cycle [NF];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected beat per output handshake, counts done cycles.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (nrst && done) done_cnt++;
            if (nrst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("out: level_hv=%04h idx=%0d last=%0b (exp %04h %0d %0b)",
                             level_hv, out_feat_idx, out_last, e.lvl, e.idx, e.last);
                    chk("level_hv", level_hv, e.lvl);
                    chk("out_feat_idx", out_feat_idx, e.idx);
                    chk("out_last", out_last, e.last);
`ifdef DEC_UNBINDER_POPCOUNT_EN
                    chk("out_popcnt", out_popcnt, $countones(e.lvl));
`endif
                    if (e.idx >= 0 && e.idx < NF) pop_cycle[e.idx] = cyc;
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start_decoding = 1'b1;
        @(posedge clk); #1 start_decoding = 1'b0;
    endtask

    task automatic send(input logic [HV-1:0] d, input logic [HV-1:0] lvl, input int idx, input bit last);
        exp_t e;
        int   guard;
        guard    = 0;
        in_valid = 1'b1;
        bound_hv = d;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("send_ready", in_ready, 1);
        if (in_ready) begin
            e.lvl = lvl; e.idx = idx; e.last = last;
            exp_q.push_back(e);
            $display("in:  bound_hv=%04h expect level_hv=%04h idx=%0d last=%0b", d, lvl, idx, last);
        end
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (busy && guard < 50);
        chk(name, busy, 0);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        #1 nrst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_level_hv", level_hv, 0);
        chk("rst_idx", out_feat_idx, 0);
        chk("rst_last", out_last, 0);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        out_ready = 1'b1;

        // in_valid while IDLE must be ignored
        in_valid = 1'b1; bound_hv = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 0);
            chk("idle_no_capture", out_valid, 0);
        end
        @(posedge clk); #1 in_valid = 1'b0;

        // Frames A/B with an ignored start pulse mid-frame
        pulse_start();
        send(16'h0008, 16'h0001, 0, 1'b0);
        send(16'h0100, 16'h0001, 1, 1'b0);
        pulse_start();
        send(16'h2000, 16'h0001, 2, 1'b0);
        send(16'h0004, 16'h0001, 3, 1'b1);
        wait_idle("idle_after_ab");
        chk("done_count_ab", done_cnt, 1);

        // Frame C: backpressure, then streaming at one beat per cycle
        out_ready = 1'b0;
        pulse_start();
        send(16'hF0F0, 16'h1E1E, 0, 1'b0);
        in_valid = 1'b1; bound_hv = 16'h1234;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_level_hv", level_hv, 16'h1E1E);
            chk("stall_idx", out_feat_idx, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(16'h1234, 16'h3412, 1, 1'b0);
        send(16'h8001, 16'h000C, 2, 1'b0);
        send(16'h00FF, 16'hC03F, 3, 1'b1);
        wait_idle("idle_after_c");
        chk("done_count_c", done_cnt, 2);
        chk("stream_rate", pop_cycle[3] - pop_cycle[0], 3);

        // Frame E: reset after two accepted beats
        pulse_start();
        send(16'h0008, 16'h0001, 0, 1'b0);
        send(16'h0100, 16'h0001, 1, 1'b0);
        nrst = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_level_hv", level_hv, 0);
        chk("midrst_idx", out_feat_idx, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_out_valid", out_valid, 0);
            chk("postrst_busy", busy, 0);
        end
        chk("no_stale_done", done_cnt, 2);
        pulse_start();
        send(16'h0004, 16'h8000, 0, 1'b0);
        send(16'h0001, 16'h0100, 1, 1'b0);
        send(16'h0001, 16'h0008, 2, 1'b0);
        send(16'h0001, 16'h4000, 3, 1'b1);
        wait_idle("idle_after_e");
        chk("done_count_e", done_cnt, 3);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dec_unbinder_seq.md
DEC_UNBINDER_SEQ -- requirements
Module: dec_unbinder_seq

Interface
REQ-001 Parameter HV_DIM, default 1024: hypervector width in bits.
REQ-002 Parameter NUM_FEATURES, default 8: bound hypervectors per decode frame.
REQ-003 Parameter SHIFT_BASE, default 93: rotation applied to feature 0.
REQ-004 Parameter SHIFT_STEP, default 1: rotation increment per feature index.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port nrst, input, 1: reset, asynchronous, active-low.
REQ-007 Port start_decoding, input, 1: one-cycle pulse that opens a frame.
REQ-008 Port in_valid, input, 1: bound_hv is valid.
REQ-009 Port in_ready, output, 1: block accepts bound_hv this cycle.
REQ-010 Port bound_hv, input, HV_DIM: shifted (bound) hypervector from the encoder side.
REQ-011 Port out_valid, output, 1: level_hv is valid.
REQ-012 Port out_ready, input, 1: downstream accepts level_hv.
REQ-013 Port level_hv, output, HV_DIM: unbound (recovered level) hypervector.
REQ-014 Port out_feat_idx, output, $clog2(NUM_FEATURES): feature index of level_hv.
REQ-015 Port out_last, output, 1: level_hv is the final feature of the frame.
REQ-016 Port busy, output, 1: high in RUN or DRAIN.
REQ-017 Port done, output, 1: one-cycle pulse at frame completion.

Function
REQ-018 The encoder binding is a left rotation: bit i moves to bit (i+S) mod HV_DIM; this block SHALL invert it: level_hv[i] = bound_hv[(i+S_k) mod HV_DIM].
REQ-019 S_k for feature k SHALL be (SHIFT_BASE + k*SHIFT_STEP) mod HV_DIM, computed with no truncation before the modulo.
REQ-020 FSM states are IDLE, RUN and DRAIN; IDLE -> RUN on start_decoding; RUN -> DRAIN on acceptance of feature NUM_FEATURES-1; DRAIN -> IDLE when the output register empties.
REQ-021 start_decoding in RUN or DRAIN SHALL be ignored.
REQ-022 in_ready SHALL be high only in RUN, and only when !out_valid || out_ready.
REQ-023 An accepted beat (in_valid && in_ready) SHALL load level_hv, out_feat_idx = k, and out_last = (k == NUM_FEATURES-1) into the output register, setting out_valid the next cycle (latency 1).
REQ-024 The feature counter k SHALL start at 0 in each frame, increment on every accepted beat, and wrap to 0 after NUM_FEATURES-1.
REQ-025 out_valid SHALL stay high with stable outputs until out_ready is high; simultaneous accept and drain SHALL sustain one beat per cycle.
REQ-026 done SHALL pulse for exactly one cycle on the DRAIN -> IDLE transition.
REQ-027 in_valid outside RUN SHALL be ignored; no data is captured.

Reset
REQ-028 When nrst is low, the block SHALL force the following asynchronously: state IDLE, k = 0, out_valid = 0, level_hv = 0, out_feat_idx = 0, out_last = 0, busy = 0, done = 0, in_ready = 0.
REQ-029 Reset asserted mid-frame SHALL discard the frame; the block SHALL produce no done pulse and no further out_valid until a new start_decoding.

Configuration
REQ-030 Macro DEC_UNBINDER_POPCOUNT_EN: when defined, the block SHALL add output out_popcnt [$clog2(HV_DIM+1)-1:0], registered alongside level_hv, equal to the number of ones in level_hv and reset to 0.
REQ-031 Without DEC_UNBINDER_POPCOUNT_EN, the out_popcnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Scenario A. Setup: HV_DIM=16, NUM_FEATURES=4, SHIFT_BASE=3, SHIFT_STEP=5. Stimulus: start, then feature 0 bound_hv=16'h0008. Required response: next cycle level_hv=16'h0001, out_feat_idx=0, out_last=0.
REQ-033 Scenario B. Setup: same as A. Stimulus: features 1..3 with bound_hv = 16'h0100, 16'h2000, 16'h0004 (S = 8, 13, 2 after wrap). Required response: each level_hv=16'h0001; out_last=1 only on index 3; one done pulse after drain.
REQ-034 Scenario C. Stimulus: hold out_ready=0 for 5 cycles with out_valid=1. Required response: in_ready=0, outputs stable; on out_ready=1, streaming resumes at one beat per cycle with no loss.
REQ-035 Scenario D. Stimulus: start_decoding during RUN, and in_valid while in IDLE. Required response: k unchanged, no capture, no extra out_valid.
REQ-036 Scenario E. Stimulus: nrst low after 2 accepted beats, then a new start. Required response: outputs clear immediately; the new frame begins at out_feat_idx=0; no stale done pulse.
REQ-037 Scenario F. Setup: DEC_UNBINDER_POPCOUNT_EN defined. Stimulus: bound_hv=16'hF0F0. Required response: out_popcnt=8.
